// File: rtl/e_m_reg_if.sv
// Execute-to-Memory bus: E-stage context and flush/stall controls in, registered M-stage slot out.
interface e_m_reg_if;
  logic        req;
  logic        stall;
  logic [31:0] E_PC;
  logic [31:0] E_instr;
  logic [31:0] E_ALUResult;
  logic [31:0] E_WD;
  logic [4:0]  E_A3;
  logic        E_MemWrite;
  logic        E_MemRead;
  logic        E_BD;
  logic        E_ExcValid;
  logic [4:0]  E_ExcCode;
  logic        OvArch;
  logic        OvDM;
  logic [31:0] M_PC;
  logic [31:0] M_instr;
  logic [31:0] M_ALUResult;
  logic [31:0] M_WD;
  logic [4:0]  M_A3;
  logic        M_MemWrite;
  logic        M_MemRead;
  logic        M_BD;
  logic        M_ExcValid;
  logic [4:0]  M_ExcCode;

  modport master (
    output req, stall, E_PC, E_instr, E_ALUResult, E_WD, E_A3,
           E_MemWrite, E_MemRead, E_BD, E_ExcValid, E_ExcCode, OvArch, OvDM,
    input  M_PC, M_instr, M_ALUResult, M_WD, M_A3,
           M_MemWrite, M_MemRead, M_BD, M_ExcValid, M_ExcCode
  );

  modport slave (
    input  req, stall, E_PC, E_instr, E_ALUResult, E_WD, E_A3,
           E_MemWrite, E_MemRead, E_BD, E_ExcValid, E_ExcCode, OvArch, OvDM,
    output M_PC, M_instr, M_ALUResult, M_WD, M_A3,
           M_MemWrite, M_MemRead, M_BD, M_ExcValid, M_ExcCode
  );
endinterface

// File: rtl/e_m_reg.sv
// E->M pipeline register with flush/stall and overflow-to-exception folding.
// Define E_M_EXC_EN to enable exception resolution and side-effect kill.
module e_m_reg #(
  parameter logic [31:0] EXC_HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  EXC_OV         = 5'd12,
  parameter logic [4:0]  EXC_ADEL       = 5'd4,
  parameter logic [4:0]  EXC_ADES       = 5'd5
) (
  input logic       clk,
  input logic       reset,
  e_m_reg_if.slave  bus
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_aluResult;
  logic [31:0] r_wd;
  logic [4:0]  r_a3;
  logic        r_memWrite;
  logic        r_memRead;
  logic        r_bd;
  logic        r_excValid;
  logic [4:0]  r_excCode;

  logic        w_excValid;
  logic [4:0]  w_excCode;

`ifdef E_M_EXC_EN
  // An earlier stage's exception outranks anything raised here; OvDM only matters for memory ops.
  always_comb begin
    w_excValid = 1'b0;
    w_excCode  = 5'd0;
    if (bus.E_ExcValid) begin
      w_excValid = 1'b1;
      w_excCode  = bus.E_ExcCode;
    end else if (bus.OvArch) begin
      w_excValid = 1'b1;
      w_excCode  = EXC_OV;
    end else if (bus.OvDM && bus.E_MemRead) begin
      w_excValid = 1'b1;
      w_excCode  = EXC_ADEL;
    end else if (bus.OvDM && bus.E_MemWrite) begin
      w_excValid = 1'b1;
      w_excCode  = EXC_ADES;
    end
  end
`else
  logic w_unusedExc;
  assign w_unusedExc = ^{bus.OvArch, bus.OvDM, bus.E_ExcValid, bus.E_ExcCode};
  assign w_excValid  = 1'b0;
  assign w_excCode   = 5'd0;
`endif

  // An excepting instruction still carries PC and BD forward so CP0 can build EPC.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_instr     <= 32'd0;
      r_aluResult <= 32'd0;
      r_wd        <= 32'd0;
      r_a3        <= 5'd0;
      r_memWrite  <= 1'b0;
      r_memRead   <= 1'b0;
      r_bd        <= 1'b0;
      r_excValid  <= 1'b0;
      r_excCode   <= 5'd0;
    end else if (bus.req) begin
      r_pc        <= EXC_HANDLER_PC;
      r_instr     <= 32'd0;
      r_aluResult <= 32'd0;
      r_wd        <= 32'd0;
      r_a3        <= 5'd0;
      r_memWrite  <= 1'b0;
      r_memRead   <= 1'b0;
      r_bd        <= 1'b0;
      r_excValid  <= 1'b0;
      r_excCode   <= 5'd0;
    end else if (!bus.stall) begin
      r_pc        <= bus.E_PC;
      r_instr     <= bus.E_instr;
      r_aluResult <= bus.E_ALUResult;
      r_wd        <= bus.E_WD;
      r_a3        <= w_excValid ? 5'd0 : bus.E_A3;
      r_memWrite  <= w_excValid ? 1'b0 : bus.E_MemWrite;
      r_memRead   <= w_excValid ? 1'b0 : bus.E_MemRead;
      r_bd        <= bus.E_BD;
      r_excValid  <= w_excValid;
      r_excCode   <= w_excCode;
    end
  end

  assign bus.M_PC        = r_pc;
  assign bus.M_instr     = r_instr;
  assign bus.M_ALUResult = r_aluResult;
  assign bus.M_WD        = r_wd;
  assign bus.M_A3        = r_a3;
  assign bus.M_MemWrite  = r_memWrite;
  assign bus.M_MemRead   = r_memRead;
  assign bus.M_BD        = r_bd;
  assign bus.M_ExcValid  = r_excValid;
  assign bus.M_ExcCode   = r_excCode;

endmodule

// File: tb/tb_e_m_reg.sv
// Self-checking bench for e_m_reg: directed steps then random traffic against a slot-level model.
module tb_e_m_reg;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  e_m_reg_if bus ();

  e_m_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  a3;
    logic        mw;
    logic        mr;
    logic        bd;
    logic        ev;
    logic [4:0]  ec;
  } mSlot_t;

  mSlot_t expSlot;

  // The M slot after one edge, from the ranking reset > flush > hold > load.
  function automatic mSlot_t predict(input mSlot_t cur);
    mSlot_t n;
    logic   isExc;
    logic [4:0] code;
    n = '0;
    if (reset) begin
      n.pc = 32'h0000_3000;
    end else if (bus.req) begin
      n.pc = 32'h0000_4180;
    end else if (bus.stall) begin
      n = cur;
    end else begin
      n.pc = bus.E_PC;     n.instr = bus.E_instr;
      n.alu = bus.E_ALUResult; n.wd = bus.E_WD;
      n.a3 = bus.E_A3;     n.mw = bus.E_MemWrite;
      n.mr = bus.E_MemRead; n.bd = bus.E_BD;
`ifdef E_M_EXC_EN
      isExc = 1'b1;
      if (bus.E_ExcValid)                      code = bus.E_ExcCode;
      else if (bus.OvArch)                     code = 5'd12;
      else if (bus.OvDM && bus.E_MemRead)      code = 5'd4;
      else if (bus.OvDM && bus.E_MemWrite)     code = 5'd5;
      else begin isExc = 1'b0; code = 5'd0; end
      n.ev = isExc;
      n.ec = code;
      if (isExc) begin n.a3 = 5'd0; n.mw = 1'b0; n.mr = 1'b0; end
`else
      isExc = 1'b0;
      code  = 5'd0;
      n.ev  = isExc;
      n.ec  = code;
`endif
    end
    return n;
  endfunction

  task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkField("M_PC",        bus.M_PC,               expSlot.pc);
    checkField("M_instr",     bus.M_instr,            expSlot.instr);
    checkField("M_ALUResult", bus.M_ALUResult,        expSlot.alu);
    checkField("M_WD",        bus.M_WD,               expSlot.wd);
    checkField("M_A3",        {27'd0, bus.M_A3},      {27'd0, expSlot.a3});
    checkField("M_MemWrite",  {31'd0, bus.M_MemWrite}, {31'd0, expSlot.mw});
    checkField("M_MemRead",   {31'd0, bus.M_MemRead},  {31'd0, expSlot.mr});
    checkField("M_BD",        {31'd0, bus.M_BD},       {31'd0, expSlot.bd});
    checkField("M_ExcValid",  {31'd0, bus.M_ExcValid}, {31'd0, expSlot.ev});
    checkField("M_ExcCode",   {27'd0, bus.M_ExcCode},  {27'd0, expSlot.ec});
  endtask

  // Advance one edge, update the model from the inputs that were live at that edge, then compare.
  task automatic applyStimulus();
    expSlot = predict(expSlot);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic clearInputs();
    reset = 1'b0;
    bus.req = 1'b0;          bus.stall = 1'b0;
    bus.E_PC = 32'd0;        bus.E_instr = 32'd0;
    bus.E_ALUResult = 32'd0; bus.E_WD = 32'd0;
    bus.E_A3 = 5'd0;         bus.E_MemWrite = 1'b0;
    bus.E_MemRead = 1'b0;    bus.E_BD = 1'b0;
    bus.E_ExcValid = 1'b0;   bus.E_ExcCode = 5'd0;
    bus.OvArch = 1'b0;       bus.OvDM = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    expSlot = '0;
    clearInputs();

    // Reset held two cycles, with garbage on the E side to prove it is ignored.
    reset = 1'b1;
    bus.E_PC = 32'hdead_beef; bus.E_A3 = 5'd7; bus.stall = 1'b1;
    applyStimulus();
    applyStimulus();
    checkField("reset_pc_const", bus.M_PC, 32'h0000_3000);

    // Normal load.
    clearInputs();
    bus.E_PC = 32'h0000_3004; bus.E_ALUResult = 32'h0000_1234; bus.E_A3 = 5'd8;
    bus.E_instr = 32'h0123_4567; bus.E_WD = 32'h89ab_cdef; bus.E_BD = 1'b1;
    applyStimulus();
    checkField("load_alu_const", bus.M_ALUResult, 32'h0000_1234);

    // Arithmetic overflow, then load and store address errors.
    clearInputs();
    bus.E_PC = 32'h0000_3008; bus.OvArch = 1'b1; bus.E_A3 = 5'd9;
    applyStimulus();
    clearInputs();
    bus.E_PC = 32'h0000_300c; bus.E_MemRead = 1'b1; bus.OvDM = 1'b1; bus.E_A3 = 5'd3;
    applyStimulus();
    clearInputs();
    bus.E_PC = 32'h0000_3010; bus.E_MemWrite = 1'b1; bus.OvDM = 1'b1;
    applyStimulus();
    clearInputs();
    bus.E_PC = 32'h0000_3014; bus.OvDM = 1'b1; bus.E_A3 = 5'd4;
    applyStimulus();

    // Priority: earlier-stage exception over OvArch, OvArch over OvDM.
    clearInputs();
    bus.E_ExcValid = 1'b1; bus.E_ExcCode = 5'd10; bus.OvArch = 1'b1; bus.E_A3 = 5'd5;
    applyStimulus();
    clearInputs();
    bus.OvArch = 1'b1; bus.OvDM = 1'b1; bus.E_MemRead = 1'b1; bus.E_A3 = 5'd6;
    applyStimulus();

    // Stall three cycles with changing inputs, then flush while still stalled, then resume.
    clearInputs();
    bus.E_PC = 32'h0000_3020; bus.E_A3 = 5'd11; bus.E_MemRead = 1'b1;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1;
      bus.E_PC = $urandom; bus.E_A3 = 5'($urandom); bus.OvArch = 1'($urandom);
      applyStimulus();
    end
    bus.req = 1'b1;
    applyStimulus();
    checkField("flush_pc_const", bus.M_PC, 32'h0000_4180);
    clearInputs();
    bus.E_PC = 32'h0000_3030; bus.E_A3 = 5'd12;
    applyStimulus();

    // Reset while stalled.
    reset = 1'b1; bus.stall = 1'b1;
    applyStimulus();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 39) == 0);
      bus.req        = ($urandom_range(0, 11) == 0);
      bus.stall      = ($urandom_range(0, 4) == 0);
      bus.E_PC       = $urandom;
      bus.E_instr    = $urandom;
      bus.E_ALUResult = $urandom;
      bus.E_WD       = $urandom;
      bus.E_A3       = 5'($urandom);
      bus.E_MemWrite = 1'($urandom);
      bus.E_MemRead  = 1'($urandom);
      bus.E_BD       = 1'($urandom);
      bus.E_ExcValid = ($urandom_range(0, 5) == 0);
      bus.E_ExcCode  = 5'($urandom);
      bus.OvArch     = ($urandom_range(0, 4) == 0);
      bus.OvDM       = ($urandom_range(0, 2) == 0);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
